uart_tx_controller: RTL and testbench
=====================================

UART_TX_CONTROLLER -- requirements
Module: uart_tx_controller

Interface
REQ-001 SHALL have parameter DW, default 8, data bits per frame.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per bit period; legal range is 1 or more.
REQ-003 SHALL have parameter STOP_BITS, default 1, number of stop bits; legal values are 1 and 2.
REQ-004 SHALL have port clk_i, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port tx_data_i, input, DW, byte to transmit.
REQ-007 SHALL have port tx_valid_i, input, 1, requester has a byte.
REQ-008 SHALL have port tx_ready_o, output, 1, controller accepts a byte this cycle.
REQ-009 SHALL have port data_o, output, DW, captured byte driven to the shift register's data input.
REQ-010 SHALL have port load_byte_o, output, 1, one-cycle load strobe to the shift register.
REQ-011 SHALL have port shift_o, output, 1, one-cycle shift strobe to the shift register.
REQ-012 SHALL have port serial_i, input, 1, current LSB-first data bit returned by the shift register.
REQ-013 SHALL have port tx_o, output, 1, UART line, registered, idle high.
REQ-014 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-015 SHALL have port done_o, output, 1, one-cycle pulse at frame end.

Function
REQ-016 SHALL implement FSM states IDLE, START, DATA and STOP.
REQ-017 SHALL drive tx_ready_o = 1 only in IDLE, combinationally from state.
REQ-018 In IDLE, on the edge where tx_valid_i & tx_ready_o, SHALL capture tx_data_i into data_o, pulse load_byte_o in the next cycle, and enter START.
REQ-019 SHALL drive tx_o = 0 throughout START, starting the cycle after the handshake, for exactly CLKS_PER_BIT cycles.
REQ-020 SHALL drive tx_o = serial_i (registered) throughout DATA, for DW bit periods of CLKS_PER_BIT cycles each.
REQ-021 In DATA, SHALL pulse shift_o at the last cycle of bit periods 0..DW-2 only, giving exactly DW-1 pulses per frame.
REQ-022 SHALL drive tx_o = 1 throughout STOP, for STOP_BITS*CLKS_PER_BIT cycles.
REQ-023 SHALL pulse done_o in the last STOP cycle and then enter IDLE.
REQ-024 SHALL size the baud counter at $clog2(STOP_BITS*CLKS_PER_BIT+1) bits and the bit counter at $clog2(DW+1) bits.
REQ-025 SHALL clear both counters on every state transition and SHALL never let them wrap.
REQ-026 SHALL ignore tx_valid_i while busy_o = 1; a byte offered then is not lost but waits for IDLE.
REQ-027 Back-to-back frames SHALL be separated by exactly one IDLE cycle with tx_o = 1.
REQ-028 With CLKS_PER_BIT = 1, SHALL produce one cycle per bit with identical state sequencing.
REQ-029 Frame length from handshake to done_o inclusive SHALL be (1+DW+STOP_BITS)*CLKS_PER_BIT cycles.

Reset
REQ-030 While rst_ni = 0, SHALL hold state = IDLE, tx_o = 1, tx_ready_o = 1, busy_o = 0, done_o = 0, load_byte_o = 0, shift_o = 0, data_o = 0, and both counters at 0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately (asynchronously).
REQ-032 After reset, SHALL accept the first handshake on the first clock edge after rst_ni deasserts.

Structure
REQ-033 SHALL place the state enum (IDLE, START, DATA, STOP) and default DW in shared package uart_pkg.
REQ-034 SHALL implement bit-period timing in one sub-module, uart_baud_counter, exposing count enable, clear and bit_end.
REQ-035 SHALL be instantiated alongside the existing shift_register; this block SHALL NOT contain the data shifter itself.

Verification
REQ-036 CLKS_PER_BIT=4, STOP_BITS=1, send 0xA5 -> tx_o = 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done_o at cycle 40 after handshake; 7 shift_o pulses; 1 load_byte_o pulse.
REQ-037 STOP_BITS=2, send 0xFF -> tx_o low 4 cycles, then high 40 cycles; done_o at cycle 44.
REQ-038 Hold tx_valid_i high with 0x01 then 0x80 -> two frames with exactly one idle-high cycle between; second frame's data bits are 0,0,0,0,0,0,0,1.
REQ-039 Pulse tx_valid_i with 0x3C during DATA of a 0x55 frame -> tx_ready_o = 0; 0x55 frame unaffected; 0x3C is not sent unless still valid in IDLE.
REQ-040 Assert rst_ni = 0 during DATA bit 3 -> tx_o = 1 and busy_o = 0 without a clock edge; next handshake produces a clean full frame.
REQ-041 CLKS_PER_BIT=1, send 0x81 -> tx_o = 0,1,0,0,0,0,0,0,1,1 on consecutive cycles; done_o at cycle 10.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared declarations for the UART transmit controller.
// Provides the controller state enum and the default data width used as the
// DW parameter default by uart_tx_controller.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    localparam int unsigned UART_DW_DEFAULT = 8;

endpackage

// File: rtl/uart_tx_controller_if.sv
// uart_tx_controller_if: bit-period timing link between the controller FSM
// and its baud counter.
//   cnt_en   - count cycles of the current bit period (controller -> counter)
//   clr      - restart the period count, asserted on state changes
//   stop_sel - current period is the whole stop field (STOP_BITS bit times)
//   bit_end  - last cycle of the current period (counter -> controller)
interface uart_tx_controller_if;
    logic cnt_en;
    logic clr;
    logic stop_sel;
    logic bit_end;

    modport master (output cnt_en, output clr, output stop_sel, input bit_end);
    modport slave  (input cnt_en, input clr, input stop_sel, output bit_end);
endinterface

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts clock cycles within one bit period and flags the
// last cycle of it.
//   clk_i, rst_ni - clock and asynchronous active-low reset
//   bus           - slave side of uart_tx_controller_if (cnt_en, clr,
//                   stop_sel in; bit_end out)
// A normal period is CLKS_PER_BIT cycles; with stop_sel the period covers the
// whole stop field, STOP_BITS*CLKS_PER_BIT cycles, so the counter is sized
// for that longer span and never wraps.
module uart_baud_counter #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    uart_tx_controller_if.slave  bus
);

    localparam int unsigned STOP_LEN = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned CW       = $clog2(STOP_LEN + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_LEN - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last      = bus.stop_sel ? (r_cnt == STOP_LAST) : (r_cnt == BIT_LAST);
    assign bus.bit_end = bus.cnt_en & w_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (bus.clr || bus.bit_end) begin
            r_cnt <= '0;
        end else if (bus.cnt_en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx_controller.sv
// uart_tx_controller: sequences one UART frame (start, DW data bits LSB first,
// STOP_BITS stop bits) around an external shift register.
//   clk_i, rst_ni           - clock, asynchronous active-low reset
//   tx_data_i/tx_valid_i    - byte offered by the requester
//   tx_ready_o              - high only in IDLE; handshake = valid & ready
//   data_o/load_byte_o      - captured byte and its load strobe to the shifter
//   shift_o                 - advance the shifter to the next data bit
//   serial_i                - data bit presented by the shifter
//   tx_o                    - registered UART line, idle high
//   busy_o/done_o           - frame in progress / last cycle of the frame
// tx_o is registered from the next state, so each line level appears in the
// same cycle the FSM enters the matching state. The shifter is expected to
// present the bit that will be current after a pending load/shift strobe, so
// registering serial_i on a period boundary picks up the new bit on time.
module uart_tx_controller
    import uart_pkg::*;
#(
    parameter int unsigned DW           = UART_DW_DEFAULT,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [DW-1:0] tx_data_i,
    input  logic          tx_valid_i,
    output logic          tx_ready_o,
    output logic [DW-1:0] data_o,
    output logic          load_byte_o,
    output logic          shift_o,
    input  logic          serial_i,
    output logic          tx_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int unsigned   BW       = $clog2(DW + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

    uart_state_e   r_state;
    uart_state_e   w_state_nxt;
    logic [BW-1:0] r_bit_cnt;
    logic [BW-1:0] w_bit_cnt_nxt;
    logic [DW-1:0] r_data;
    logic          r_load;
    logic          r_tx;
    logic          w_accept;
    logic          w_shift;
    logic          w_done;

    uart_tx_controller_if w_baud ();

    uart_baud_counter #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .STOP_BITS    (STOP_BITS)
    ) u_baud (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (w_baud)
    );

    // Counter control depends only on the registered state, keeping bit_end
    // free of any path back through the next-state logic.
    assign w_baud.cnt_en   = (r_state != IDLE);
    assign w_baud.stop_sel = (r_state == STOP);
    assign w_baud.clr      = (w_state_nxt != r_state);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_accept      = 1'b0;
        w_shift       = 1'b0;
        w_done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (tx_valid_i) begin
                    w_accept    = 1'b1;
                    w_state_nxt = START;
                end
            end
            START: begin
                if (w_baud.bit_end) w_state_nxt = DATA;
            end
            DATA: begin
                if (w_baud.bit_end) begin
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_nxt = STOP;
                    end else begin
                        // the final data bit needs no shift, so DW-1 strobes
                        w_shift       = 1'b1;
                        w_bit_cnt_nxt = r_bit_cnt + BW'(1);
                    end
                end
            end
            STOP: begin
                if (w_baud.bit_end) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_state_nxt != r_state) w_bit_cnt_nxt = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_data <= '0;
            r_load <= 1'b0;
            r_tx   <= 1'b1;
        end else begin
            r_load <= w_accept;
            if (w_accept) r_data <= tx_data_i;
            case (w_state_nxt)
                START:   r_tx <= 1'b0;
                DATA:    r_tx <= serial_i;
                default: r_tx <= 1'b1;
            endcase
        end
    end

    assign tx_ready_o  = (r_state == IDLE);
    assign busy_o      = (r_state != IDLE);
    assign done_o      = w_done;
    assign shift_o     = w_shift;
    assign load_byte_o = r_load;
    assign data_o      = r_data;
    assign tx_o        = r_tx;

endmodule

// File: tb/tb_uart_tx_controller.sv
// tb_uart_tx_controller: three controller instances (4 clk/bit 1 stop,
// 4 clk/bit 2 stop, 1 clk/bit 1 stop), each paired with a small shift
// register model. Expected line levels and strobes come from frame arithmetic:
// cycle k after the handshake falls in start, data bit (k-c-1)/c, or stop.
module tb_uart_tx_controller;

    localparam int NI = 3;
    int cpb_a  [NI] = '{4, 4, 1};
    int stop_a [NI] = '{1, 2, 1};

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    tx_data;
    logic [NI-1:0] tx_valid, tx_ready, load, shift, serial, tx, busy, done;
    logic [7:0]    dout [NI];
    logic [7:0]    sh   [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_controller #(.DW(8), .CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid[0]),
        .tx_ready_o(tx_ready[0]), .data_o(dout[0]), .load_byte_o(load[0]),
        .shift_o(shift[0]), .serial_i(serial[0]), .tx_o(tx[0]), .busy_o(busy[0]),
        .done_o(done[0]));

    uart_tx_controller #(.DW(8), .CLKS_PER_BIT(4), .STOP_BITS(2)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid[1]),
        .tx_ready_o(tx_ready[1]), .data_o(dout[1]), .load_byte_o(load[1]),
        .shift_o(shift[1]), .serial_i(serial[1]), .tx_o(tx[1]), .busy_o(busy[1]),
        .done_o(done[1]));

    uart_tx_controller #(.DW(8), .CLKS_PER_BIT(1), .STOP_BITS(1)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid[2]),
        .tx_ready_o(tx_ready[2]), .data_o(dout[2]), .load_byte_o(load[2]),
        .shift_o(shift[2]), .serial_i(serial[2]), .tx_o(tx[2]), .busy_o(busy[2]),
        .done_o(done[2]));

    // Shift register: loads on load, shifts right on shift, and presents the
    // LSB it will hold after any pending strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) sh[i] <= '0;
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (load[i])       sh[i] <= dout[i];
                else if (shift[i]) sh[i] <= {1'b0, sh[i][7:1]};
            end
        end
    end

    always_comb begin
        serial = '0;
        for (int i = 0; i < NI; i++)
            serial[i] = load[i] ? dout[i][0] : (shift[i] ? sh[i][1] : sh[i][0]);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic int frame_len(input int w);
        return (1 + 8 + stop_a[w]) * cpb_a[w];
    endfunction

    function automatic logic exp_tx(input int w, input logic [7:0] b, input int k);
        int c = cpb_a[w];
        if (k <= c)     return 1'b0;
        if (k <= 9 * c) return b[(k - c - 1) / c];
        return 1'b1;
    endfunction

    // shift at the end of data bit periods 0..6
    function automatic logic exp_shift(input int w, input int k);
        int c = cpb_a[w];
        return (k >= 2 * c) && (k <= 8 * c) && ((k % c) == 0);
    endfunction

    // Called at a negedge with instance w idle; returns at the negedge of the
    // first cycle after done. mode 1: keep valid high, offering nb next.
    // mode 2: offer nb for one cycle at frame cycle poke_k.
    task automatic frame(input int w, input logic [7:0] b, input int mode,
                         input logic [7:0] nb, input int poke_k);
        int len  = frame_len(w);
        int n_sh = 0;
        int n_ld = 0;
        tx_data     = b;
        tx_valid[w] = 1'b1;
        check($sformatf("i%0d ready_idle", w), tx_ready[w], 1);
        @(posedge clk);
        @(negedge clk);
        if (mode == 1) tx_data = nb;
        else           tx_valid[w] = 1'b0;
        for (int k = 1; k <= len; k++) begin
            if (mode == 2 && k == poke_k)     begin tx_data = nb; tx_valid[w] = 1'b1; end
            if (mode == 2 && k == poke_k + 1) tx_valid[w] = 1'b0;
            check($sformatf("i%0d b%02h tx k%0d", w, b, k), tx[w], exp_tx(w, b, k));
            check($sformatf("i%0d done k%0d", w, k), done[w], (k == len));
            check($sformatf("i%0d shift k%0d", w, k), shift[w], exp_shift(w, k));
            check($sformatf("i%0d load k%0d", w, k), load[w], (k == 1));
            check($sformatf("i%0d busy k%0d", w, k), busy[w], 1);
            check($sformatf("i%0d ready k%0d", w, k), tx_ready[w], 0);
            if (k == 1 || k == len) check($sformatf("i%0d data_o k%0d", w, k), dout[w], b);
            n_sh += int'(shift[w]);
            n_ld += int'(load[w]);
            @(negedge clk);
        end
        check($sformatf("i%0d n_shift", w), n_sh, 7);
        check($sformatf("i%0d n_load", w), n_ld, 1);
        check($sformatf("i%0d gap_tx", w), tx[w], 1);
        check($sformatf("i%0d gap_busy", w), busy[w], 0);
        check($sformatf("i%0d gap_ready", w), tx_ready[w], 1);
    endtask

    task automatic idle(input int w, input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            check($sformatf("i%0d idle_tx", w), tx[w], 1);
            check($sformatf("i%0d idle_busy", w), busy[w], 0);
            check($sformatf("i%0d idle_done", w), done[w], 0);
        end
    endtask

    initial begin
        logic [7:0] b, nb;
        int         w, pk;
        rst_n    = 1'b1;
        tx_valid = '0;
        tx_data  = '0;
        #1 rst_n = 1'b0;
        tx_valid = '1;
        tx_data  = 8'h5A;
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("i%0d rst tx", i), tx[i], 1);
            check($sformatf("i%0d rst ready", i), tx_ready[i], 1);
            check($sformatf("i%0d rst busy", i), busy[i], 0);
            check($sformatf("i%0d rst done", i), done[i], 0);
            check($sformatf("i%0d rst load", i), load[i], 0);
            check($sformatf("i%0d rst shift", i), shift[i], 0);
            check($sformatf("i%0d rst data_o", i), dout[i], 0);
        end
        tx_valid = '0;
        rst_n    = 1'b1;
        idle(0, 1);

        // directed frames
        frame(0, 8'hA5, 0, 8'h00, 0); idle(0, 2);
        frame(1, 8'hFF, 0, 8'h00, 0); idle(1, 1);
        frame(2, 8'h81, 0, 8'h00, 0); idle(2, 1);

        // held valid: back-to-back with a single idle cycle between
        frame(0, 8'h01, 1, 8'h80, 0);
        frame(0, 8'h80, 0, 8'h00, 0); idle(0, 1);

        // byte offered mid-frame is ignored and not sent afterwards
        frame(0, 8'h55, 2, 8'h3C, 20); idle(0, 4);

        // asynchronous reset during data bit 3 of 0xC3
        tx_data     = 8'hC3;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tx_valid[0] = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_rst tx", tx[0], exp_tx(0, 8'hC3, 18));
        check("pre_rst busy", busy[0], 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort tx", tx[0], 1);
        check("abort busy", busy[0], 0);
        check("abort ready", tx_ready[0], 1);
        check("abort data_o", dout[0], 0);
        check("abort shift", shift[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        frame(0, 8'h96, 0, 8'h00, 0); idle(0, 1);

        // randomized frames across all instances
        for (int it = 0; it < 15; it++) begin
            w  = int'($urandom_range(0, NI - 1));
            b  = 8'($urandom);
            nb = 8'($urandom);
            case ($urandom_range(0, 3))
                0: begin
                    frame(w, b, 1, nb, 0);
                    frame(w, nb, 0, 8'h00, 0);
                end
                1: begin
                    pk = int'($urandom_range(2, frame_len(w) - 1));
                    frame(w, b, 2, nb, pk);
                end
                default: frame(w, b, 0, 8'h00, 0);
            endcase
            idle(w, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
